// File: rtl/axi_rr_burst_arbiter.sv
// axi_rr_burst_arbiter: round-robin sharing of one AXI4 master port between I$ (port 0) and D$ (port 1)
module axi_rr_burst_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     i_s0_arid,
    input  logic [ADDR_WIDTH-1:0]   i_s0_araddr,
    input  logic [7:0]              i_s0_arlen,
    input  logic [2:0]              i_s0_arsize,
    input  logic [1:0]              i_s0_arburst,
    input  logic                    i_s0_arvalid,
    output logic                    o_s0_arready,
    output logic [ID_WIDTH-1:0]     o_s0_rid,
    output logic [DATA_WIDTH-1:0]   o_s0_rdata,
    output logic [1:0]              o_s0_rresp,
    output logic                    o_s0_rlast,
    output logic                    o_s0_rvalid,
    input  logic                    i_s0_rready,
    input  logic [ID_WIDTH-1:0]     i_s0_awid,
    input  logic [ADDR_WIDTH-1:0]   i_s0_awaddr,
    input  logic [7:0]              i_s0_awlen,
    input  logic [2:0]              i_s0_awsize,
    input  logic [1:0]              i_s0_awburst,
    input  logic                    i_s0_awvalid,
    output logic                    o_s0_awready,
    input  logic [DATA_WIDTH-1:0]   i_s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_s0_wstrb,
    input  logic                    i_s0_wlast,
    input  logic                    i_s0_wvalid,
    output logic                    o_s0_wready,
    output logic [ID_WIDTH-1:0]     o_s0_bid,
    output logic [1:0]              o_s0_bresp,
    output logic                    o_s0_bvalid,
    input  logic                    i_s0_bready,
    input  logic [ID_WIDTH-1:0]     i_s1_arid,
    input  logic [ADDR_WIDTH-1:0]   i_s1_araddr,
    input  logic [7:0]              i_s1_arlen,
    input  logic [2:0]              i_s1_arsize,
    input  logic [1:0]              i_s1_arburst,
    input  logic                    i_s1_arvalid,
    output logic                    o_s1_arready,
    output logic [ID_WIDTH-1:0]     o_s1_rid,
    output logic [DATA_WIDTH-1:0]   o_s1_rdata,
    output logic [1:0]              o_s1_rresp,
    output logic                    o_s1_rlast,
    output logic                    o_s1_rvalid,
    input  logic                    i_s1_rready,
    input  logic [ID_WIDTH-1:0]     i_s1_awid,
    input  logic [ADDR_WIDTH-1:0]   i_s1_awaddr,
    input  logic [7:0]              i_s1_awlen,
    input  logic [2:0]              i_s1_awsize,
    input  logic [1:0]              i_s1_awburst,
    input  logic                    i_s1_awvalid,
    output logic                    o_s1_awready,
    input  logic [DATA_WIDTH-1:0]   i_s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_s1_wstrb,
    input  logic                    i_s1_wlast,
    input  logic                    i_s1_wvalid,
    output logic                    o_s1_wready,
    output logic [ID_WIDTH-1:0]     o_s1_bid,
    output logic [1:0]              o_s1_bresp,
    output logic                    o_s1_bvalid,
    input  logic                    i_s1_bready,
    output logic [ID_WIDTH-1:0]     o_m_arid,
    output logic [ADDR_WIDTH-1:0]   o_m_araddr,
    output logic [7:0]              o_m_arlen,
    output logic [2:0]              o_m_arsize,
    output logic [1:0]              o_m_arburst,
    output logic                    o_m_arvalid,
    input  logic                    i_m_arready,
    input  logic [ID_WIDTH-1:0]     i_m_rid,
    input  logic [DATA_WIDTH-1:0]   i_m_rdata,
    input  logic [1:0]              i_m_rresp,
    input  logic                    i_m_rlast,
    input  logic                    i_m_rvalid,
    output logic                    o_m_rready,
    output logic [ID_WIDTH-1:0]     o_m_awid,
    output logic [ADDR_WIDTH-1:0]   o_m_awaddr,
    output logic [7:0]              o_m_awlen,
    output logic [2:0]              o_m_awsize,
    output logic [1:0]              o_m_awburst,
    output logic                    o_m_awvalid,
    input  logic                    i_m_awready,
    output logic [DATA_WIDTH-1:0]   o_m_wdata,
    output logic [DATA_WIDTH/8-1:0] o_m_wstrb,
    output logic                    o_m_wlast,
    output logic                    o_m_wvalid,
    input  logic                    i_m_wready,
    input  logic [ID_WIDTH-1:0]     i_m_bid,
    input  logic [1:0]              i_m_bresp,
    input  logic                    i_m_bvalid,
    output logic                    o_m_bready,
    output logic [1:0]              o_grant,
    output logic                    o_rd_busy,
    output logic                    o_wr_busy,
    output logic                    o_burst_err,
    input  logic                    i_burst_err_clr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_rr_ptr, r_rr_vld;
    logic [7:0] r_beat_cnt, r_exp_len;
    logic       r_burst_err;

    logic w_rd, w_wr, w_rd0, w_rd1, w_wr0, w_wr1;
    logic w_req0, w_req1, w_pick, w_pick_aw, w_grant_now;
    logic w_ar_hs, w_r_hs, w_b_hs, w_err_set;

    // Routing selects come only from registered state and owner so nothing glitches toward the idle port
    assign w_rd  = (r_state == READ);
    assign w_wr  = (r_state == WRITE);
    assign w_rd0 = w_rd & ~r_owner;
    assign w_rd1 = w_rd &  r_owner;
    assign w_wr0 = w_wr & ~r_owner;
    assign w_wr1 = w_wr &  r_owner;

    // A tie goes to the port that did not win last; before any grant port 0 wins
    assign w_req0      = i_s0_arvalid | i_s0_awvalid;
    assign w_req1      = i_s1_arvalid | i_s1_awvalid;
    assign w_pick      = (w_req0 & w_req1) ? (r_rr_vld & ~r_rr_ptr) : w_req1;
    assign w_pick_aw   = w_pick ? i_s1_awvalid : i_s0_awvalid;
    assign w_grant_now = (r_state == IDLE) & (w_req0 | w_req1);

    assign w_ar_hs   = o_m_arvalid & i_m_arready;
    assign w_r_hs    = i_m_rvalid & o_m_rready;
    assign w_b_hs    = i_m_bvalid & o_m_bready;
    assign w_err_set = w_rd & w_r_hs & (i_m_rlast ? (r_beat_cnt != r_exp_len) : (r_beat_cnt == r_exp_len));

    assign o_m_arid    = w_rd ? (r_owner ? i_s1_arid    : i_s0_arid)    : '0;
    assign o_m_araddr  = w_rd ? (r_owner ? i_s1_araddr  : i_s0_araddr)  : '0;
    assign o_m_arlen   = w_rd ? (r_owner ? i_s1_arlen   : i_s0_arlen)   : '0;
    assign o_m_arsize  = w_rd ? (r_owner ? i_s1_arsize  : i_s0_arsize)  : '0;
    assign o_m_arburst = w_rd ? (r_owner ? i_s1_arburst : i_s0_arburst) : '0;
    assign o_m_arvalid = w_rd ? (r_owner ? i_s1_arvalid : i_s0_arvalid) : 1'b0;
    assign o_m_rready  = w_rd ? (r_owner ? i_s1_rready  : i_s0_rready)  : 1'b0;
    assign o_m_awid    = w_wr ? (r_owner ? i_s1_awid    : i_s0_awid)    : '0;
    assign o_m_awaddr  = w_wr ? (r_owner ? i_s1_awaddr  : i_s0_awaddr)  : '0;
    assign o_m_awlen   = w_wr ? (r_owner ? i_s1_awlen   : i_s0_awlen)   : '0;
    assign o_m_awsize  = w_wr ? (r_owner ? i_s1_awsize  : i_s0_awsize)  : '0;
    assign o_m_awburst = w_wr ? (r_owner ? i_s1_awburst : i_s0_awburst) : '0;
    assign o_m_awvalid = w_wr ? (r_owner ? i_s1_awvalid : i_s0_awvalid) : 1'b0;
    assign o_m_wdata   = w_wr ? (r_owner ? i_s1_wdata   : i_s0_wdata)   : '0;
    assign o_m_wstrb   = w_wr ? (r_owner ? i_s1_wstrb   : i_s0_wstrb)   : '0;
    assign o_m_wlast   = w_wr ? (r_owner ? i_s1_wlast   : i_s0_wlast)   : 1'b0;
    assign o_m_wvalid  = w_wr ? (r_owner ? i_s1_wvalid  : i_s0_wvalid)  : 1'b0;
    assign o_m_bready  = w_wr ? (r_owner ? i_s1_bready  : i_s0_bready)  : 1'b0;

    assign o_s0_arready = w_rd0 & i_m_arready;
    assign o_s0_rid     = w_rd0 ? i_m_rid   : '0;
    assign o_s0_rdata   = w_rd0 ? i_m_rdata : '0;
    assign o_s0_rresp   = w_rd0 ? i_m_rresp : '0;
    assign o_s0_rlast   = w_rd0 & i_m_rlast;
    assign o_s0_rvalid  = w_rd0 & i_m_rvalid;
    assign o_s0_awready = w_wr0 & i_m_awready;
    assign o_s0_wready  = w_wr0 & i_m_wready;
    assign o_s0_bid     = w_wr0 ? i_m_bid   : '0;
    assign o_s0_bresp   = w_wr0 ? i_m_bresp : '0;
    assign o_s0_bvalid  = w_wr0 & i_m_bvalid;

    assign o_s1_arready = w_rd1 & i_m_arready;
    assign o_s1_rid     = w_rd1 ? i_m_rid   : '0;
    assign o_s1_rdata   = w_rd1 ? i_m_rdata : '0;
    assign o_s1_rresp   = w_rd1 ? i_m_rresp : '0;
    assign o_s1_rlast   = w_rd1 & i_m_rlast;
    assign o_s1_rvalid  = w_rd1 & i_m_rvalid;
    assign o_s1_awready = w_wr1 & i_m_awready;
    assign o_s1_wready  = w_wr1 & i_m_wready;
    assign o_s1_bid     = w_wr1 ? i_m_bid   : '0;
    assign o_s1_bresp   = w_wr1 ? i_m_bresp : '0;
    assign o_s1_bvalid  = w_wr1 & i_m_bvalid;

    assign o_grant     = (r_state == IDLE) ? 2'b00 : {r_owner, ~r_owner};
    assign o_rd_busy   = w_rd;
    assign o_wr_busy   = w_wr;
    assign o_burst_err = r_burst_err;

    // Next state: grant from IDLE (write wins within a port), release on rlast or B handshake
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_grant_now) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = w_pick_aw ? WRITE : READ;
                end
            end
            READ:    if (w_r_hs & i_m_rlast) w_state_nxt = IDLE;
            WRITE:   if (w_b_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and owner registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Round-robin history, read beat tracking and sticky length-mismatch flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= 1'b0;
            r_rr_vld    <= 1'b0;
            r_beat_cnt  <= '0;
            r_exp_len   <= '0;
            r_burst_err <= 1'b0;
        end else begin
            if (w_grant_now) begin
                r_rr_ptr <= w_pick;
                r_rr_vld <= 1'b1;
            end
            if (w_ar_hs) begin
                r_exp_len  <= o_m_arlen;
                r_beat_cnt <= '0;
            end else if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            r_burst_err <= w_err_set ? 1'b1 : (i_burst_err_clr ? 1'b0 : r_burst_err);
        end
    end
endmodule

// File: tb/tb_axi_rr_burst_arbiter.sv
// tb_axi_rr_burst_arbiter: directed checks of grant timing, round-robin, write/read ordering and rlast checking
module tb_axi_rr_burst_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_s0_arid, i_s0_awid, i_s1_arid, i_s1_awid, i_m_rid, i_m_bid;
    logic [31:0] i_s0_araddr, i_s0_awaddr, i_s1_araddr, i_s1_awaddr;
    logic [7:0]  i_s0_arlen, i_s0_awlen, i_s1_arlen, i_s1_awlen;
    logic [2:0]  i_s0_arsize, i_s0_awsize, i_s1_arsize, i_s1_awsize;
    logic [1:0]  i_s0_arburst, i_s0_awburst, i_s1_arburst, i_s1_awburst;
    logic        i_s0_arvalid, i_s0_rready, i_s0_awvalid, i_s0_wlast, i_s0_wvalid, i_s0_bready;
    logic        i_s1_arvalid, i_s1_rready, i_s1_awvalid, i_s1_wlast, i_s1_wvalid, i_s1_bready;
    logic [31:0] i_s0_wdata, i_s1_wdata, i_m_rdata;
    logic [3:0]  i_s0_wstrb, i_s1_wstrb;
    logic        i_m_arready, i_m_rlast, i_m_rvalid, i_m_awready, i_m_wready, i_m_bvalid;
    logic [1:0]  i_m_rresp, i_m_bresp;
    logic        i_burst_err_clr;
    logic        o_s0_arready, o_s0_rlast, o_s0_rvalid, o_s0_awready, o_s0_wready, o_s0_bvalid;
    logic        o_s1_arready, o_s1_rlast, o_s1_rvalid, o_s1_awready, o_s1_wready, o_s1_bvalid;
    logic [3:0]  o_s0_rid, o_s0_bid, o_s1_rid, o_s1_bid, o_m_arid, o_m_awid;
    logic [31:0] o_s0_rdata, o_s1_rdata, o_m_araddr, o_m_awaddr, o_m_wdata;
    logic [1:0]  o_s0_rresp, o_s0_bresp, o_s1_rresp, o_s1_bresp;
    logic [7:0]  o_m_arlen, o_m_awlen;
    logic [2:0]  o_m_arsize, o_m_awsize;
    logic [1:0]  o_m_arburst, o_m_awburst;
    logic        o_m_arvalid, o_m_rready, o_m_awvalid, o_m_wlast, o_m_wvalid, o_m_bready;
    logic [3:0]  o_m_wstrb;
    logic [1:0]  o_grant;
    logic        o_rd_busy, o_wr_busy, o_burst_err;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    axi_rr_burst_arbiter #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_s0_arid(i_s0_arid), .i_s0_araddr(i_s0_araddr), .i_s0_arlen(i_s0_arlen), .i_s0_arsize(i_s0_arsize),
        .i_s0_arburst(i_s0_arburst), .i_s0_arvalid(i_s0_arvalid), .o_s0_arready(o_s0_arready),
        .o_s0_rid(o_s0_rid), .o_s0_rdata(o_s0_rdata), .o_s0_rresp(o_s0_rresp), .o_s0_rlast(o_s0_rlast),
        .o_s0_rvalid(o_s0_rvalid), .i_s0_rready(i_s0_rready),
        .i_s0_awid(i_s0_awid), .i_s0_awaddr(i_s0_awaddr), .i_s0_awlen(i_s0_awlen), .i_s0_awsize(i_s0_awsize),
        .i_s0_awburst(i_s0_awburst), .i_s0_awvalid(i_s0_awvalid), .o_s0_awready(o_s0_awready),
        .i_s0_wdata(i_s0_wdata), .i_s0_wstrb(i_s0_wstrb), .i_s0_wlast(i_s0_wlast), .i_s0_wvalid(i_s0_wvalid),
        .o_s0_wready(o_s0_wready), .o_s0_bid(o_s0_bid), .o_s0_bresp(o_s0_bresp), .o_s0_bvalid(o_s0_bvalid),
        .i_s0_bready(i_s0_bready),
        .i_s1_arid(i_s1_arid), .i_s1_araddr(i_s1_araddr), .i_s1_arlen(i_s1_arlen), .i_s1_arsize(i_s1_arsize),
        .i_s1_arburst(i_s1_arburst), .i_s1_arvalid(i_s1_arvalid), .o_s1_arready(o_s1_arready),
        .o_s1_rid(o_s1_rid), .o_s1_rdata(o_s1_rdata), .o_s1_rresp(o_s1_rresp), .o_s1_rlast(o_s1_rlast),
        .o_s1_rvalid(o_s1_rvalid), .i_s1_rready(i_s1_rready),
        .i_s1_awid(i_s1_awid), .i_s1_awaddr(i_s1_awaddr), .i_s1_awlen(i_s1_awlen), .i_s1_awsize(i_s1_awsize),
        .i_s1_awburst(i_s1_awburst), .i_s1_awvalid(i_s1_awvalid), .o_s1_awready(o_s1_awready),
        .i_s1_wdata(i_s1_wdata), .i_s1_wstrb(i_s1_wstrb), .i_s1_wlast(i_s1_wlast), .i_s1_wvalid(i_s1_wvalid),
        .o_s1_wready(o_s1_wready), .o_s1_bid(o_s1_bid), .o_s1_bresp(o_s1_bresp), .o_s1_bvalid(o_s1_bvalid),
        .i_s1_bready(i_s1_bready),
        .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize),
        .o_m_arburst(o_m_arburst), .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready),
        .i_m_rid(i_m_rid), .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast),
        .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
        .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen), .o_m_awsize(o_m_awsize),
        .o_m_awburst(o_m_awburst), .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready),
        .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .o_m_wlast(o_m_wlast), .o_m_wvalid(o_m_wvalid),
        .i_m_wready(i_m_wready), .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid),
        .o_m_bready(o_m_bready),
        .o_grant(o_grant), .o_rd_busy(o_rd_busy), .o_wr_busy(o_wr_busy), .o_burst_err(o_burst_err),
        .i_burst_err_clr(i_burst_err_clr)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {i_s0_arid, i_s0_awid, i_s1_arid, i_s1_awid, i_m_rid, i_m_bid} = '0;
        {i_s0_araddr, i_s0_awaddr, i_s1_araddr, i_s1_awaddr} = '0;
        {i_s0_arlen, i_s0_awlen, i_s1_arlen, i_s1_awlen} = '0;
        {i_s0_arsize, i_s0_awsize, i_s1_arsize, i_s1_awsize} = '0;
        {i_s0_arburst, i_s0_awburst, i_s1_arburst, i_s1_awburst} = '0;
        {i_s0_arvalid, i_s0_rready, i_s0_awvalid, i_s0_wlast, i_s0_wvalid, i_s0_bready} = '0;
        {i_s1_arvalid, i_s1_rready, i_s1_awvalid, i_s1_wlast, i_s1_wvalid, i_s1_bready} = '0;
        {i_s0_wdata, i_s1_wdata, i_m_rdata, i_s0_wstrb, i_s1_wstrb} = '0;
        {i_m_arready, i_m_rlast, i_m_rvalid, i_m_awready, i_m_wready, i_m_bvalid} = '0;
        {i_m_rresp, i_m_bresp, i_burst_err_clr} = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        nxt();
        nxt();
        smp();
        check("rst grant", o_grant, 2'b00);
        check("rst rd_busy", o_rd_busy, 0);
        check("rst wr_busy", o_wr_busy, 0);
        check("rst burst_err", o_burst_err, 0);
        check("rst m_arvalid", o_m_arvalid, 0);
        rst_n = 1'b1;
        nxt();
        // single read burst from port 0, arlen=3
        i_s0_arvalid = 1; i_s0_araddr = 32'h1000; i_s0_arlen = 8'd3; i_m_arready = 1;
        smp();
        check("t1 idle m_arvalid", o_m_arvalid, 0);
        check("t1 idle s0_arready", o_s0_arready, 0);
        nxt();
        smp();
        check("t1 grant", o_grant, 2'b01);
        check("t1 rd_busy", o_rd_busy, 1);
        check("t1 m_arvalid", o_m_arvalid, 1);
        check("t1 m_araddr", o_m_araddr, 32'h1000);
        check("t1 m_arlen", o_m_arlen, 3);
        check("t1 s0_arready", o_s0_arready, 1);
        nxt();
        i_s0_arvalid = 0; i_m_arready = 0; i_s0_rready = 1; i_s1_rready = 1; i_m_rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            i_m_rdata = 32'hA0 + k;
            i_m_rlast = (k == 3);
            smp();
            check("t1 s0_rdata", o_s0_rdata, 32'hA0 + k);
            check("t1 s0_rvalid", o_s0_rvalid, 1);
            check("t1 s1_rvalid", o_s1_rvalid, 0);
            nxt();
        end
        i_m_rvalid = 0; i_m_rlast = 0;
        smp();
        check("t1 end grant", o_grant, 2'b00);
        check("t1 end burst_err", o_burst_err, 0);
        nxt();
        // rlast arrives on the third beat of an arlen=3 burst
        i_s0_arvalid = 1; i_s0_arlen = 8'd3; i_m_arready = 1;
        smp();
        nxt();
        smp();
        check("t4 grant", o_grant, 2'b01);
        nxt();
        i_s0_arvalid = 0; i_m_arready = 0; i_m_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            i_m_rlast = (k == 2);
            smp();
            check("t4 err before", o_burst_err, 0);
            nxt();
        end
        i_m_rvalid = 0; i_m_rlast = 0;
        smp();
        check("t4 burst_err set", o_burst_err, 1);
        check("t4 rd_busy", o_rd_busy, 0);
        nxt();
        i_burst_err_clr = 1;
        smp();
        check("t4 err held", o_burst_err, 1);
        nxt();
        i_burst_err_clr = 0;
        smp();
        check("t4 err cleared", o_burst_err, 0);
        nxt();
        // reset in the middle of a read burst
        i_s0_arvalid = 1; i_s0_arlen = 8'd3; i_m_arready = 1;
        smp();
        nxt();
        smp();
        nxt();
        i_s0_arvalid = 0; i_m_arready = 0; i_m_rvalid = 1;
        for (int k = 0; k < 2; k++) begin
            smp();
            nxt();
        end
        rst_n = 0;
        smp();
        check("t5 pre-reset rd_busy", o_rd_busy, 1);
        nxt();
        rst_n = 1; i_m_rvalid = 0;
        smp();
        check("t5 grant", o_grant, 2'b00);
        check("t5 rd_busy", o_rd_busy, 0);
        check("t5 m_arvalid", o_m_arvalid, 0);
        check("t5 m_awvalid", o_m_awvalid, 0);
        check("t5 m_wvalid", o_m_wvalid, 0);
        check("t5 m_rready", o_m_rready, 0);
        nxt();
        // sustained contention, arlen=0 bursts alternate owners starting at port 0
        i_s0_arvalid = 1; i_s1_arvalid = 1; i_s0_arlen = 0; i_s1_arlen = 0;
        for (int b = 0; b < 4; b++) begin
            i_m_arready = 1;
            smp();
            check("t2 idle grant", o_grant, 2'b00);
            nxt();
            smp();
            check("t2 grant", o_grant, (b % 2) ? 2'b10 : 2'b01);
            check("t2 m_arvalid", o_m_arvalid, 1);
            nxt();
            i_m_arready = 0; i_m_rvalid = 1; i_m_rlast = 1;
            smp();
            check("t2 s1_rvalid", o_s1_rvalid, (b % 2) ? 1 : 0);
            nxt();
            i_m_rvalid = 0; i_m_rlast = 0;
        end
        i_s0_arvalid = 0; i_s1_arvalid = 0;
        smp();
        check("t2 burst_err", o_burst_err, 0);
        nxt();
        // port 1 asks for write and read together: write first, then read
        i_s1_awvalid = 1; i_s1_awlen = 8'd7; i_s1_awaddr = 32'h2000;
        i_s1_arvalid = 1; i_s1_arlen = 8'd0; i_s1_araddr = 32'h3000;
        i_m_awready = 1; i_m_arready = 1;
        smp();
        nxt();
        smp();
        check("t3 wr_busy", o_wr_busy, 1);
        check("t3 grant", o_grant, 2'b10);
        check("t3 m_awvalid", o_m_awvalid, 1);
        check("t3 m_awlen", o_m_awlen, 7);
        check("t3 m_awaddr", o_m_awaddr, 32'h2000);
        check("t3 m_arvalid", o_m_arvalid, 0);
        check("t3 s1_awready", o_s1_awready, 1);
        check("t3 s1_arready", o_s1_arready, 0);
        check("t3 s0_awready", o_s0_awready, 0);
        nxt();
        i_s1_awvalid = 0; i_m_awready = 0; i_m_wready = 1; i_s1_wvalid = 1; i_s1_wstrb = 4'hF;
        for (int k = 0; k < 8; k++) begin
            i_s1_wdata = 32'h5500 + k;
            i_s1_wlast = (k == 7);
            smp();
            check("t3 m_wdata", o_m_wdata, 32'h5500 + k);
            check("t3 s1_wready", o_s1_wready, 1);
            check("t3 s0_wready", o_s0_wready, 0);
            nxt();
        end
        i_s1_wvalid = 0; i_s1_wlast = 0; i_m_bvalid = 1; i_m_bid = 4'h5; i_s1_bready = 1;
        smp();
        check("t3 s1_bvalid", o_s1_bvalid, 1);
        check("t3 s1_bid", o_s1_bid, 4'h5);
        check("t3 s0_bvalid", o_s0_bvalid, 0);
        check("t3 m_bready", o_m_bready, 1);
        nxt();
        i_m_bvalid = 0;
        smp();
        check("t3 dead grant", o_grant, 2'b00);
        check("t3 dead s1_arready", o_s1_arready, 0);
        nxt();
        smp();
        check("t3 rd grant", o_grant, 2'b10);
        check("t3 rd_busy", o_rd_busy, 1);
        check("t3 m_araddr", o_m_araddr, 32'h3000);
        check("t3 s1_arready", o_s1_arready, 1);
        check("t3 s0_arready", o_s0_arready, 0);
        nxt();
        i_s1_arvalid = 0; i_m_arready = 0; i_m_rvalid = 1; i_m_rlast = 1;
        smp();
        check("t3 s1_rvalid", o_s1_rvalid, 1);
        nxt();
        i_m_rvalid = 0; i_m_rlast = 0;
        smp();
        check("t3 end grant", o_grant, 2'b00);
        nxt();
        // port 0 writes with a slow B while port 1 waits with arvalid held
        i_s0_awvalid = 1; i_s0_awlen = 8'd0; i_s1_arvalid = 1; i_m_awready = 1; i_m_arready = 1;
        smp();
        nxt();
        smp();
        check("t6 grant", o_grant, 2'b01);
        check("t6 wr_busy", o_wr_busy, 1);
        check("t6 s1_arready", o_s1_arready, 0);
        nxt();
        i_s0_awvalid = 0; i_m_awready = 0; i_s0_wvalid = 1; i_s0_wlast = 1; i_m_wready = 1;
        smp();
        nxt();
        i_s0_wvalid = 0; i_s0_wlast = 0; i_s0_bready = 1;
        for (int k = 0; k < 10; k++) begin
            smp();
            check("t6 wait s1_arready", o_s1_arready, 0);
            check("t6 wait grant", o_grant, 2'b01);
            nxt();
        end
        i_m_bvalid = 1;
        smp();
        check("t6 s0_bvalid", o_s0_bvalid, 1);
        nxt();
        i_m_bvalid = 0;
        smp();
        check("t6 dead grant", o_grant, 2'b00);
        check("t6 dead s1_arready", o_s1_arready, 0);
        nxt();
        smp();
        check("t6 s1 grant", o_grant, 2'b10);
        check("t6 s1_arready", o_s1_arready, 1);
        nxt();
        i_s1_arvalid = 0; i_m_arready = 0; i_m_rvalid = 1; i_m_rlast = 1;
        smp();
        nxt();
        i_m_rvalid = 0; i_m_rlast = 0;
        smp();
        check("t6 end grant", o_grant, 2'b00);
        check("t6 end burst_err", o_burst_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
